// File: rtl/fp_round_arbiter.sv
// Round-robin arbiter feeding a shared FP rounding stage with a single-entry valid/ready output register.
// Optional per-requester stall counters: define FP_ROUND_ARB_PERF_EN.
module fp_round_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 3,
  parameter  int TAG_WIDTH  = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [2:0]                     frm_i,
  input  logic [NUM_REQ-1:0]             in_valid_i,
  output logic [NUM_REQ-1:0]             in_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_abs_i,
  input  logic [NUM_REQ-1:0]             in_sign_i,
  input  logic [NUM_REQ*2-1:0]           in_rs_i,
  input  logic [NUM_REQ*3-1:0]           in_rm_i,
  input  logic [NUM_REQ-1:0]             in_effsub_i,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   in_tag_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DATA_WIDTH-1:0]          out_abs_o,
  output logic                           out_sign_o,
  output logic                           out_zero_o,
  output logic                           out_nx_o,
  output logic                           out_nv_rm_o,
  output logic [ID_W-1:0]                out_req_id_o,
  output logic [TAG_WIDTH-1:0]           out_tag_o
`ifdef FP_ROUND_ARB_PERF_EN
  ,
  input  logic                           perf_clr_i,
  output logic [NUM_REQ*32-1:0]          perf_stall_o
`endif
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_DYN = 3'b111;

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_abs_q, out_abs_d;
  logic                  out_sign_q, out_sign_d;
  logic                  out_zero_q, out_zero_d;
  logic                  out_nx_q, out_nx_d;
  logic                  out_nv_q, out_nv_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_idx, scan_idx;
  logic                  can_accept, fire;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && in_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Reset gates the grant combinationally so nothing is accepted while reset_n is low.
  assign can_accept = !out_valid_q || out_ready_i;
  assign fire       = gnt_found && can_accept && reset_n;

  always_comb begin
    in_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_ready_o[i] = fire && (gnt_idx == ID_W'(i));
    end
  end

  logic [DATA_WIDTH-1:0] sel_abs;
  logic                  sel_sign, sel_effsub, sel_r, sel_s;
  logic [2:0]            sel_rm, eff_rm, rnd_rm;
  logic                  rm_nv, round_up, res_zero, res_sign;
  logic [DATA_WIDTH-1:0] res_abs;

  always_comb begin
    sel_abs    = in_abs_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_sign   = in_sign_i[gnt_idx];
    sel_effsub = in_effsub_i[gnt_idx];
    {sel_r, sel_s} = in_rs_i[int'(gnt_idx)*2 +: 2];
    sel_rm     = in_rm_i[int'(gnt_idx)*3 +: 3];

    eff_rm = (sel_rm == RM_DYN) ? frm_i : sel_rm;
    rm_nv  = (eff_rm == 3'b101) || (eff_rm == 3'b110) || (eff_rm == 3'b111);
    rnd_rm = rm_nv ? RM_RNE : eff_rm;

    case (rnd_rm)
      RM_RNE:  round_up = sel_r & (sel_s | sel_abs[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = (sel_r | sel_s) & sel_sign;
      RM_RUP:  round_up = (sel_r | sel_s) & ~sel_sign;
      default: round_up = sel_r;
    endcase

    // Carry out of the magnitude wraps; the producer owns exponent adjustment.
    res_abs  = sel_abs + DATA_WIDTH'(round_up);
    res_zero = (sel_abs == '0) && !(sel_r | sel_s);
    res_sign = (res_zero && sel_effsub) ? (eff_rm == RM_RDN) : sel_sign;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_abs_d   = out_abs_q;
    out_sign_d  = out_sign_q;
    out_zero_d  = out_zero_q;
    out_nx_d    = out_nx_q;
    out_nv_d    = out_nv_q;
    out_id_d    = out_id_q;
    out_tag_d   = out_tag_q;
    if (fire) begin
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      out_valid_d = 1'b1;
      out_abs_d   = res_abs;
      out_sign_d  = res_sign;
      out_zero_d  = res_zero;
      out_nx_d    = sel_r | sel_s;
      out_nv_d    = rm_nv;
      out_id_d    = gnt_idx;
      out_tag_d   = in_tag_i[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_abs_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_nx_q    <= 1'b0;
      out_nv_q    <= 1'b0;
      out_id_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_abs_q   <= out_abs_d;
      out_sign_q  <= out_sign_d;
      out_zero_q  <= out_zero_d;
      out_nx_q    <= out_nx_d;
      out_nv_q    <= out_nv_d;
      out_id_q    <= out_id_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_abs_o    = out_abs_q;
  assign out_sign_o   = out_sign_q;
  assign out_zero_o   = out_zero_q;
  assign out_nx_o     = out_nx_q;
  assign out_nv_rm_o  = out_nv_q;
  assign out_req_id_o = out_id_q;
  assign out_tag_o    = out_tag_q;

`ifdef FP_ROUND_ARB_PERF_EN
  logic [31:0] stall_q [NUM_REQ];
  logic [31:0] stall_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stall_d[i] = stall_q[i];
      if (perf_clr_i)                          stall_d[i] = '0;
      else if (in_valid_i[i] && !in_ready_o[i]) stall_d[i] = stall_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) stall_q[i] <= stall_d[i];
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    assign perf_stall_o[gi*32 +: 32] = stall_q[gi];
  end
`endif

endmodule

// File: tb/tb_fp_round_arbiter.sv
// Randomized plus directed bench for fp_round_arbiter, checked against a transaction-level model.
// Define FP_ROUND_ARB_PERF_EN to also check the stall counters.
module tb_fp_round_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      frm = '0;
  logic            out_ready = 1'b0;
  logic [N-1:0]    v = '0, sg = '0, es = '0;
  logic [DW-1:0]   a_abs [N];
  logic [1:0]      a_rs  [N];
  logic [2:0]      a_rm  [N];
  logic [TW-1:0]   a_tag [N];

  logic [N-1:0]    in_ready_o;
  logic [N*DW-1:0] in_abs_i;
  logic [N*2-1:0]  in_rs_i;
  logic [N*3-1:0]  in_rm_i;
  logic [N*TW-1:0] in_tag_i;
  logic            out_valid_o, out_sign_o, out_zero_o, out_nx_o, out_nv_rm_o;
  logic [DW-1:0]   out_abs_o;
  logic [1:0]      out_req_id_o;
  logic [TW-1:0]   out_tag_o;
`ifdef FP_ROUND_ARB_PERF_EN
  logic            perf_clr = 1'b0;
  logic [N*32-1:0] perf_stall_o;
  int unsigned     m_cnt [N];
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_bus
    assign in_abs_i[gi*DW +: DW] = a_abs[gi];
    assign in_rs_i[gi*2 +: 2]    = a_rs[gi];
    assign in_rm_i[gi*3 +: 3]    = a_rm[gi];
    assign in_tag_i[gi*TW +: TW] = a_tag[gi];
  end

  fp_round_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .frm_i(frm),
    .in_valid_i(v), .in_ready_o(in_ready_o), .in_abs_i(in_abs_i), .in_sign_i(sg),
    .in_rs_i(in_rs_i), .in_rm_i(in_rm_i), .in_effsub_i(es), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_abs_o(out_abs_o),
    .out_sign_o(out_sign_o), .out_zero_o(out_zero_o), .out_nx_o(out_nx_o),
    .out_nv_rm_o(out_nv_rm_o), .out_req_id_o(out_req_id_o), .out_tag_o(out_tag_o)
`ifdef FP_ROUND_ARB_PERF_EN
    , .perf_clr_i(perf_clr), .perf_stall_o(perf_stall_o)
`endif
  );

  typedef struct {
    logic [DW-1:0] abs;
    logic          sign, zero, nx, nv;
  } res_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit          m_valid = 1'b0;
  res_t        m_res;
  int          m_id = 0;
  logic [TW-1:0] m_tag = '0;
  int          m_ptr = 0;
  logic [N-1:0] last_acc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Rounding decided from the fraction beyond the LSB: R is the half bit, S anything below it.
  function automatic res_t model_round(input logic [DW-1:0] a, input logic s, input logic [1:0] rs,
                                       input logic [2:0] rm, input logic e, input logic [2:0] f);
    res_t r;
    int   eff, mode;
    bit   half, below, inexact, up;
    eff     = (rm == 3'd7) ? int'(f) : int'(rm);
    mode    = (eff >= 5) ? 0 : eff;
    half    = rs[1];
    below   = rs[0];
    inexact = half || below;
    case (mode)
      0:       up = (half && below) || (half && !below && a[0]);
      1:       up = 1'b0;
      2:       up = inexact && s;
      3:       up = inexact && !s;
      default: up = half;
    endcase
    r.abs  = a + (up ? 32'd1 : 32'd0);
    r.nx   = inexact;
    r.nv   = (eff >= 5);
    r.zero = (a == 0) && !inexact;
    r.sign = (r.zero && e) ? (eff == 2) : s;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    last_acc = '0;
`ifdef FP_ROUND_ARB_PERF_EN
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
  endtask

  // One clock: check the combinational grant mid-cycle, advance the model, check registered outputs.
  task automatic step();
    bit           found, can;
    int           g;
    logic [N-1:0] er;
    @(negedge clk);
    can   = !m_valid || out_ready;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (!found && v[i]) begin
        found = 1'b1;
        g     = i;
      end
    end
    er = (found && can) ? N'(1 << g) : '0;
    check("in_ready", in_ready_o, er);
`ifdef FP_ROUND_ARB_PERF_EN
    for (int i = 0; i < N; i++) begin
      if (perf_clr) m_cnt[i] = 0;
      else if (v[i] && !er[i]) m_cnt[i] = m_cnt[i] + 1;
    end
`endif
    last_acc = er;
    if (found && can) begin
      m_res   = model_round(a_abs[g], sg[g], a_rs[g], a_rm[g], es[g], frm);
      m_valid = 1'b1;
      m_id    = g;
      m_tag   = a_tag[g];
      m_ptr   = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid_o, m_valid);
    if (m_valid) begin
      check("out_abs", out_abs_o, m_res.abs);
      check("out_flags", {out_sign_o, out_zero_o, out_nx_o, out_nv_rm_o},
            {m_res.sign, m_res.zero, m_res.nx, m_res.nv});
      check("out_id", out_req_id_o, m_id);
      check("out_tag", out_tag_o, m_tag);
    end
`ifdef FP_ROUND_ARB_PERF_EN
    for (int i = 0; i < N; i++) check("perf_cnt", perf_stall_o[i*32 +: 32], m_cnt[i]);
`endif
  endtask

  task automatic drive(input int i, input logic vv, input logic [DW-1:0] a, input logic s,
                       input logic [1:0] rs, input logic [2:0] rm, input logic e,
                       input logic [TW-1:0] t);
    v[i] = vv; a_abs[i] = a; sg[i] = s; a_rs[i] = rs; a_rm[i] = rm; es[i] = e; a_tag[i] = t;
  endtask

  initial begin
    for (int i = 0; i < N; i++) drive(i, 1'b1, 32'h100 + i, 1'b0, 2'b11, 3'b000, 1'b0, TW'(8'hA0 + i));
    // Reset state: requests pending yet nothing granted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_ready", in_ready_o, '0);
    check("rst_data", {out_abs_o, out_sign_o, out_zero_o, out_nx_o, out_nv_rm_o, out_req_id_o, out_tag_o}, '0);
    model_reset();
    reset_n = 1'b1;
    v = '0;
    out_ready = 1'b1;

    // Single requester RNE.
    drive(0, 1'b1, 32'h11, 1'b0, 2'b10, 3'b000, 1'b0, 8'h01);
    step();
    check("rne_up", out_abs_o, 32'h12);
    check("rne_id", out_req_id_o, 0);
    drive(0, 1'b1, 32'h10, 1'b0, 2'b10, 3'b000, 1'b0, 8'h02);
    step();
    check("rne_tie_even", out_abs_o, 32'h10);
    v = '0;
    step();

    // Round robin with all requesters held valid.
    for (int i = 0; i < N; i++) drive(i, 1'b1, 32'h20 + i, 1'(i), 2'(i), 3'(i), 1'b0, TW'(8'h30 + i));
    repeat (6) step();

    // Backpressure: outputs hold, no grant, then resume.
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    v = '0;
    step();

    // Dynamic rounding mode.
    drive(0, 1'b1, 32'h7, 1'b0, 2'b01, 3'b111, 1'b0, 8'h40);
    frm = 3'b011;
    step();
    check("frm_rup", {out_abs_o, out_nv_rm_o}, {32'h8, 1'b0});
    frm = 3'b101;
    step();
    check("frm_bad", {out_abs_o, out_nv_rm_o}, {32'h7, 1'b1});
    frm = 3'b000;

    // Exact zero sign and magnitude wrap.
    drive(0, 1'b1, 32'h0, 1'b0, 2'b00, 3'b010, 1'b1, 8'h50);
    step();
    check("zero_rdn", {out_zero_o, out_sign_o}, 2'b11);
    drive(0, 1'b1, 32'h0, 1'b0, 2'b00, 3'b000, 1'b1, 8'h51);
    step();
    check("zero_rne", {out_zero_o, out_sign_o}, 2'b10);
    drive(0, 1'b1, 32'hFFFF_FFFF, 1'b0, 2'b11, 3'b000, 1'b0, 8'h52);
    step();
    check("wrap", {out_abs_o, out_nx_o, out_zero_o}, {32'h0, 1'b1, 1'b0});

    // Asynchronous reset while a result is held and requests are pending.
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    out_ready = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid_o, 1'b0);
    check("arst_ready", in_ready_o, '0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    v = 3'b110;
    out_ready = 1'b1;
    step();
    check("arst_first", out_req_id_o, 1);

`ifdef FP_ROUND_ARB_PERF_EN
    // Requester 1 blocked behind a held result for five cycles.
    v = 3'b001;
    out_ready = 1'b0;
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    v = 3'b010;
    repeat (5) step();
    check("perf_five", perf_stall_o[63:32], 32'd5);
    out_ready = 1'b1;
`endif

    // Randomized traffic; a requester keeps its operand until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !last_acc[i])) begin
          logic [DW-1:0] a;
          case ($urandom_range(0, 7))
            0:       a = 32'hFFFF_FFFF;
            1:       a = 32'h0;
            default: a = $urandom;
          endcase
          drive(i, 1'($urandom_range(0, 3) != 0), a, 1'($urandom), 2'($urandom),
                3'($urandom), 1'($urandom), 8'($urandom));
        end
      end
      frm = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef FP_ROUND_ARB_PERF_EN
      perf_clr = ($urandom_range(0, 63) == 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
